stw_test_sequencer: RTL and testbench

STW_TEST_SEQUENCER -- requirements
Module: stw_test_sequencer

---
 rtl/stw_test_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_stw_test_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stw_test_sequencer.sv
// Self-test sequencer for an array of PEs: walks a fixed table of four
// multiply-add vectors through every PE in parallel, waits for each PE's
// STW handshake (complete drops low, then rises high), and accumulates a
// sticky per-PE fault map that downstream bypass/proxy logic can use.
module stw_test_sequencer #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_PE    = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 test_start,
   input  logic [NUM_PE-1:0]    stw_complete,
   input  logic [NUM_PE-1:0]    stw_result,
   output logic [NUM_PE-1:0]    stw_test_load_en,
   output logic [NUM_PE-1:0]    stw_start,
   output logic [WORD_SIZE-1:0] stw_mult_op1,
   output logic [WORD_SIZE-1:0] stw_mult_op2,
   output logic [WORD_SIZE-1:0] stw_add_op,
   output logic [WORD_SIZE-1:0] stw_expected,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_PE-1:0]    fault_map
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_LOW,
      WAIT_HIGH,
      CHECK,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [1:0]       index;
   logic [CNT_W-1:0] wait_cnt;
   logic             timed_out;
   logic             cnt_expired;
   logic             enter_load;
   logic [1:0]       load_idx;
   logic [WORD_SIZE-1:0] nxt_op1;
   logic [WORD_SIZE-1:0] nxt_op2;
   logic [WORD_SIZE-1:0] nxt_add;
   logic [WORD_SIZE-1:0] nxt_exp;

   // Vector table: multiplier operand 1.
   function automatic logic [WORD_SIZE-1:0] vec_op1(input logic [1:0] idx);
      case (idx)
         2'd0:    vec_op1 = WORD_SIZE'(1);
         2'd1:    vec_op1 = {WORD_SIZE{1'b1}};
         2'd2:    vec_op1 = WORD_SIZE'(16'h5555);
         default: vec_op1 = WORD_SIZE'(16'h00FF);
      endcase
   endfunction

   // Vector table: multiplier operand 2.
   function automatic logic [WORD_SIZE-1:0] vec_op2(input logic [1:0] idx);
      case (idx)
         2'd0:    vec_op2 = WORD_SIZE'(1);
         2'd1:    vec_op2 = WORD_SIZE'(1);
         2'd2:    vec_op2 = WORD_SIZE'(2);
         default: vec_op2 = WORD_SIZE'(16'h0100);
      endcase
   endfunction

   // Vector table: addend.
   function automatic logic [WORD_SIZE-1:0] vec_add(input logic [1:0] idx);
      case (idx)
         2'd0:    vec_add = WORD_SIZE'(0);
         2'd1:    vec_add = WORD_SIZE'(1);
         2'd2:    vec_add = WORD_SIZE'(0);
         default: vec_add = WORD_SIZE'(16'h00FF);
      endcase
   endfunction

   assign cnt_expired = (wait_cnt == CNT_LAST);
   assign enter_load  = (state_next == LOAD);
   assign load_idx    = (state == IDLE) ? 2'd0 : index + 2'd1;
   assign nxt_op1     = vec_op1(load_idx);
   assign nxt_op2     = vec_op2(load_idx);
   assign nxt_add     = vec_add(load_idx);
   assign nxt_exp     = nxt_op1 * nxt_op2 + nxt_add;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; an expired wait counter wins over the handshake.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (test_start) state_next = LOAD;
         LOAD:      state_next = START;
         START:     state_next = WAIT_LOW;
         WAIT_LOW: begin
            if (cnt_expired)                 state_next = CHECK;
            else if (stw_complete == '0)     state_next = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (cnt_expired)                 state_next = CHECK;
            else if (&stw_complete)          state_next = CHECK;
         end
         CHECK:     state_next = (index < 2'd3) ? LOAD : DONE;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      stw_test_load_en = '0;
      stw_start        = '0;
      busy             = 1'b0;
      done             = 1'b0;
      case (state)
         LOAD: begin
            stw_test_load_en = '1;
            busy             = 1'b1;
         end
         START: begin
            stw_start = '1;
            busy      = 1'b1;
         end
         WAIT_LOW, WAIT_HIGH, CHECK: busy = 1'b1;
         DONE:    done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Datapath: vector index, wait counter, timeout flag, fault map and the
   // operand registers, which only change on entry to LOAD so they stay put
   // for the whole LOAD..CHECK window of a vector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         index        <= '0;
         wait_cnt     <= '0;
         timed_out    <= 1'b0;
         fault_map    <= '0;
         stw_mult_op1 <= '0;
         stw_mult_op2 <= '0;
         stw_add_op   <= '0;
         stw_expected <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (test_start) begin
                  fault_map <= '0;
                  index     <= '0;
               end
            end
            START: wait_cnt <= '0;
            WAIT_LOW, WAIT_HIGH: begin
               wait_cnt <= wait_cnt + CNT_W'(1);
               if (cnt_expired) timed_out <= 1'b1;
            end
            CHECK: begin
               fault_map <= fault_map | ~stw_result
                            | (timed_out ? ~stw_complete : '0);
               timed_out <= 1'b0;
               index     <= index + 2'd1;
            end
            default: ;
         endcase
         if (enter_load) begin
            stw_mult_op1 <= nxt_op1;
            stw_mult_op2 <= nxt_op2;
            stw_add_op   <= nxt_add;
            stw_expected <= nxt_exp;
         end
      end
   end

endmodule

// File: tb/tb_stw_test_sequencer.sv
// Self-checking bench for stw_test_sequencer: behavioural PE models answer
// the STW handshake with random latencies, and each pass is checked against
// the fault map and timing predicted from the scenario configuration.
module tb_stw_test_sequencer;

   localparam int WS  = 16;
   localparam int NPE = 4;
   localparam int TO  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           test_start;
   logic [NPE-1:0] stw_complete = '0;
   logic [NPE-1:0] stw_result   = '0;
   logic [NPE-1:0] stw_test_load_en;
   logic [NPE-1:0] stw_start;
   logic [WS-1:0]  stw_mult_op1;
   logic [WS-1:0]  stw_mult_op2;
   logic [WS-1:0]  stw_add_op;
   logic [WS-1:0]  stw_expected;
   logic           busy;
   logic           done;
   logic [NPE-1:0] fault_map;

   int checks = 0;
   int errors = 0;

   // Reference vector table, with the expected adder results written out
   // as the wrapped 16-bit values.
   logic [15:0] tOp1 [4] = '{16'h0001, 16'hFFFF, 16'h5555, 16'h00FF};
   logic [15:0] tOp2 [4] = '{16'h0001, 16'h0001, 16'h0002, 16'h0100};
   logic [15:0] tAdd [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h00FF};
   logic [15:0] tExp [4] = '{16'h0001, 16'h0000, 16'hAAAA, 16'hFFFF};

   // Scenario configuration read by the PE models.
   logic [NPE-1:0] failVec [4];
   logic [NPE-1:0] stuck1Mask;
   logic [NPE-1:0] stuck0Mask;
   int             minD;
   int             maxD;

   // PE model state.
   int             peTimer [NPE];
   logic [NPE-1:0] peFail;
   int             peVec;
   int             vecMaxd [4];

   stw_test_sequencer #(.WORD_SIZE(WS), .NUM_PE(NPE), .TIMEOUT(TO)) dut (
      .clk              (clk),
      .rst              (rst),
      .test_start       (test_start),
      .stw_complete     (stw_complete),
      .stw_result       (stw_result),
      .stw_test_load_en (stw_test_load_en),
      .stw_start        (stw_start),
      .stw_mult_op1     (stw_mult_op1),
      .stw_mult_op2     (stw_mult_op2),
      .stw_add_op       (stw_add_op),
      .stw_expected     (stw_expected),
      .busy             (busy),
      .done             (done),
      .fault_map        (fault_map)
   );

   always #5 clk = ~clk;

   // PE models: on a start strobe a healthy PE drops complete, waits a random
   // number of cycles, then raises complete with its pass/fail result. Stuck
   // PEs hold complete at a fixed level regardless of the strobe.
   always @(negedge clk) begin
      int vi;
      if (!busy) peVec = 0;
      vi = (peVec > 3) ? 3 : peVec;
      if (stw_start != '0) vecMaxd[vi] = 0;
      for (int p = 0; p < NPE; p++) begin
         if (stuck1Mask[p]) begin
            stw_complete[p] = 1'b1;
            stw_result[p]   = 1'b0;
         end else if (stuck0Mask[p]) begin
            stw_complete[p] = 1'b0;
            stw_result[p]   = 1'b1;
         end else if (stw_start[p]) begin
            stw_complete[p] = 1'b0;
            stw_result[p]   = 1'b0;
            peTimer[p]      = int'($urandom_range(maxD, minD));
            peFail[p]       = failVec[vi][p];
            if (peTimer[p] > vecMaxd[vi]) vecMaxd[vi] = peTimer[p];
         end else if (peTimer[p] > 0) begin
            peTimer[p] = peTimer[p] - 1;
            if (peTimer[p] == 0) begin
               stw_complete[p] = 1'b1;
               stw_result[p]   = ~peFail[p];
            end
         end
      end
      if (stw_start != '0) peVec = peVec + 1;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Puts every PE back to healthy, passing behaviour.
   task automatic clearConfig();
      for (int v = 0; v < 4; v++) failVec[v] = '0;
      stuck1Mask = '0;
      stuck0Mask = '0;
      minD       = 2;
      maxD       = 5;
   endtask

   // Runs one full pass and checks the load/start sequence, operands, wait
   // lengths, the done pulse and the resulting fault map against the model.
   task automatic applyStimulus(input string name, input bit pulseBusy);
      logic [NPE-1:0] expFault;
      bit             timeoutExp;
      int             loads, starts, dones, gap, cyc, firstLoad, postDone, unstable;
      bit             inGap, pulsed;
      logic [63:0]    latched;
      expFault   = stuck1Mask | stuck0Mask;
      for (int v = 0; v < 4; v++) expFault |= failVec[v];
      timeoutExp = ((stuck1Mask | stuck0Mask) != '0);
      loads = 0; starts = 0; dones = 0; gap = 0; cyc = 0;
      firstLoad = -1; postDone = 0; unstable = 0;
      inGap = 1'b0; pulsed = 1'b0; latched = '0;
      @(negedge clk);
      test_start = 1'b1;
      while (cyc < 300 && postDone < 3) begin
         @(negedge clk);
         cyc++;
         test_start = 1'b0;
         if (stw_test_load_en != '0) begin
            checkOutput({name, " load_en"}, 64'(stw_test_load_en), 64'hF);
            if (firstLoad < 0) firstLoad = cyc;
            if (inGap)
               checkOutput({name, " wait_len"}, 64'(gap),
                           64'(timeoutExp ? TO + 1 : vecMaxd[starts-1] + 1));
            if (loads < 4) begin
               checkOutput({name, " op1"}, 64'(stw_mult_op1), 64'(tOp1[loads]));
               checkOutput({name, " op2"}, 64'(stw_mult_op2), 64'(tOp2[loads]));
               checkOutput({name, " add"}, 64'(stw_add_op), 64'(tAdd[loads]));
               checkOutput({name, " expected"}, 64'(stw_expected), 64'(tExp[loads]));
            end
            latched = {stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected};
            loads++;
            inGap = 1'b0;
         end else if (stw_start != '0) begin
            checkOutput({name, " start"}, 64'(stw_start), 64'hF);
            starts++;
            inGap = 1'b1;
            gap   = 0;
         end else if (done) begin
            checkOutput({name, " busy_at_done"}, 64'(busy), 64'h0);
            if (inGap)
               checkOutput({name, " wait_len"}, 64'(gap),
                           64'(timeoutExp ? TO + 1 : vecMaxd[starts-1] + 1));
            inGap = 1'b0;
            dones++;
         end else if (inGap) begin
            gap++;
         end
         if (busy && stw_test_load_en == '0 &&
             {stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected} != latched)
            unstable++;
         if (dones > 0) postDone++;
         if (pulseBusy && !pulsed && starts == 2) begin
            test_start = 1'b1;
            pulsed     = 1'b1;
         end
      end
      test_start = 1'b0;
      checkOutput({name, " first_load_cycle"}, 64'(firstLoad), 64'd1);
      checkOutput({name, " loads"}, 64'(loads), 64'd4);
      checkOutput({name, " starts"}, 64'(starts), 64'd4);
      checkOutput({name, " dones"}, 64'(dones), 64'd1);
      checkOutput({name, " operand_stability"}, 64'(unstable), 64'd0);
      checkOutput({name, " fault_map"}, 64'(fault_map), 64'(expFault));
      checkOutput({name, " busy_after"}, 64'(busy), 64'h0);
      repeat (4) @(negedge clk);
      checkOutput({name, " fault_map_hold"}, 64'(fault_map), 64'(expFault));
   endtask

   // Scenario sequence.
   initial begin
      int starts, after, doneDuring, r, p;
      rst        = 1'b0;
      test_start = 1'b0;
      for (int i = 0; i < NPE; i++) peTimer[i] = 0;
      peFail = '0;
      clearConfig();
      repeat (3) @(negedge clk);
      checkOutput("reset_ctrl",
                  64'({stw_test_load_en, stw_start, busy, done, fault_map}), 64'h0);
      checkOutput("reset_ops",
                  {stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected}, 64'h0);
      rst = 1'b1;

      $display("[TB] all PEs pass");
      applyStimulus("all_pass", 1'b0);

      $display("[TB] PE2 fails on V1");
      clearConfig();
      failVec[1] = 4'b0100;
      applyStimulus("pe2_v1", 1'b0);

      $display("[TB] PE0 complete stuck high");
      clearConfig();
      stuck1Mask = 4'b0001;
      applyStimulus("pe0_stuck1", 1'b0);

      $display("[TB] PE3 complete stuck low");
      clearConfig();
      stuck0Mask = 4'b1000;
      applyStimulus("pe3_stuck0", 1'b0);

      $display("[TB] test_start pulsed while busy");
      clearConfig();
      applyStimulus("start_busy", 1'b1);

      $display("[TB] reset during WAIT_HIGH of V2");
      clearConfig();
      failVec[0] = 4'b0010;
      minD = 4;
      maxD = 4;
      starts = 0;
      after  = 0;
      @(negedge clk);
      test_start = 1'b1;
      for (int c = 0; c < 200 && after < 2; c++) begin
         @(negedge clk);
         test_start = 1'b0;
         if (starts == 3) after++;
         if (stw_start != '0) starts++;
      end
      checkOutput("abort_reached_v2", 64'(starts), 64'd3);
      checkOutput("abort_fault_before", 64'(fault_map), 64'h2);
      #2 rst = 1'b0;
      #1;
      checkOutput("abort_ctrl",
                  64'({stw_test_load_en, stw_start, busy, done, fault_map}), 64'h0);
      checkOutput("abort_ops",
                  {stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected}, 64'h0);
      doneDuring = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) doneDuring++;
         if (c == 2) rst = 1'b1;
      end
      checkOutput("abort_no_done", 64'(doneDuring), 64'd0);
      checkOutput("abort_idle", 64'({busy, fault_map}), 64'h0);
      clearConfig();
      applyStimulus("after_abort", 1'b0);

      $display("[TB] back-to-back passes, PE3 fails only in pass 1");
      clearConfig();
      failVec[$urandom_range(3, 0)] = 4'b1000;
      applyStimulus("b2b_pass1", 1'b0);
      clearConfig();
      applyStimulus("b2b_pass2", 1'b0);

      $display("[TB] randomized passes");
      for (int n = 0; n < 6; n++) begin
         clearConfig();
         for (int v = 0; v < 4; v++)
            failVec[v] = ($urandom_range(3, 0) == 0) ? NPE'($urandom) : '0;
         r = int'($urandom_range(5, 0));
         p = int'($urandom_range(NPE - 1, 0));
         if (r == 0) stuck1Mask[p] = 1'b1;
         else if (r == 1) stuck0Mask[p] = 1'b1;
         applyStimulus("random", 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
